// File: rtl/mem_host_arbiter_if.sv
// Bus bundle between the requesting hosts, the arbiter and the shared SRAM.
// The arbiter connects through the slave modport; the host/memory side
// (testbench or surrounding SoC glue) connects through the master modport.
interface mem_host_arbiter_if #(
    parameter int NumHosts  = 2,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    localparam int BeWidth = DataWidth / 8;

    // host side
    logic [NumHosts-1:0]           host_req_i;
    logic [NumHosts-1:0]           host_we_i;
    logic [NumHosts*AddrWidth-1:0] host_addr_i;
    logic [NumHosts*BeWidth-1:0]   host_be_i;
    logic [NumHosts*DataWidth-1:0] host_wdata_i;
    logic [NumHosts-1:0]           host_gnt_o;
    logic [NumHosts-1:0]           host_rvalid_o;
    logic [NumHosts-1:0]           host_err_o;
    logic [DataWidth-1:0]          host_rdata_o;

    // memory side
    logic                          mem_req_o;
    logic                          mem_we_o;
    logic [AddrWidth-1:0]          mem_addr_o;
    logic [BeWidth-1:0]            mem_be_o;
    logic [DataWidth-1:0]          mem_wdata_o;
    logic                          mem_rvalid_i;
    logic [DataWidth-1:0]          mem_rdata_i;

    // status
    logic [15:0]                   err_count_o;

    modport slave (
        input  host_req_i, host_we_i, host_addr_i, host_be_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_rvalid_i, mem_rdata_i,
        output err_count_o
    );

    modport master (
        output host_req_i, host_we_i, host_addr_i, host_be_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_rvalid_i, mem_rdata_i,
        input  err_count_o
    );
endinterface

// File: rtl/mem_host_arbiter.sv
// N-host to single-SRAM arbiter: same-cycle grant (fixed priority or
// round-robin), SRAM window decode, one-cycle response routing back to the
// granted host, error responses for unmapped addresses and a saturating
// error counter.
module mem_host_arbiter #(
    parameter int          NumHosts   = 2,
    parameter int          AddrWidth  = 32,
    parameter int          DataWidth  = 32,
    parameter logic [31:0] MemStart   = 32'h0000_0000,
    parameter int          MemSize    = 65536,
    parameter bit          RoundRobin = 1'b1
) (
    input  logic clk_sys,
    input  logic rst_sys_n,
    mem_host_arbiter_if.slave bus
);
    localparam int BeWidth = DataWidth / 8;
    localparam int HostW   = (NumHosts > 1) ? $clog2(NumHosts) : 1;

    localparam logic [AddrWidth-1:0] WinMask   = ~AddrWidth'(MemSize - 1);
    localparam logic [AddrWidth-1:0] WinBase   = AddrWidth'(MemStart);
    localparam logic [HostW:0]       NumHostsW = (HostW + 1)'(NumHosts);
    localparam logic [HostW-1:0]     LastHost  = HostW'(NumHosts - 1);

    // unpacked views of the packed per-host buses
    logic [AddrWidth-1:0] addr_arr  [NumHosts];
    logic [BeWidth-1:0]   be_arr    [NumHosts];
    logic [DataWidth-1:0] wdata_arr [NumHosts];

    logic [HostW-1:0] last_q;
    logic             rsp_valid_q;
    logic [HostW-1:0] rsp_host_q;
    logic             rsp_err_q;
    logic [15:0]      err_count_q;

    logic             any_gnt;
    logic [HostW-1:0] win_idx;
    logic [HostW:0]   cand;
    logic             win_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NumHosts; gi++) begin : g_host
            assign addr_arr[gi]  = bus.host_addr_i[gi*AddrWidth +: AddrWidth];
            assign be_arr[gi]    = bus.host_be_i[gi*BeWidth +: BeWidth];
            assign wdata_arr[gi] = bus.host_wdata_i[gi*DataWidth +: DataWidth];

            assign bus.host_gnt_o[gi]    = any_gnt && (win_idx == HostW'(gi));
            assign bus.host_rvalid_o[gi] = rsp_valid_q && (rsp_host_q == HostW'(gi))
                                           && (rsp_err_q || bus.mem_rvalid_i);
            assign bus.host_err_o[gi]    = rsp_valid_q && (rsp_host_q == HostW'(gi))
                                           && rsp_err_q;
        end
    endgenerate

    // Pick the winner: search upward from last_q+1 (round-robin) or from
    // host 0 (fixed priority). The rotated index stays below 2*NumHosts, so
    // a single conditional subtract implements the wrap. No grants in reset.
    always_comb begin
        any_gnt = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NumHosts; k++) begin
            if (RoundRobin) begin
                cand = {1'b0, last_q} + (HostW + 1)'(k + 1);
                if (cand >= NumHostsW) begin
                    cand = cand - NumHostsW;
                end
            end else begin
                cand = (HostW + 1)'(k);
            end
            if (!any_gnt && bus.host_req_i[cand[HostW-1:0]]) begin
                any_gnt = 1'b1;
                win_idx = cand[HostW-1:0];
            end
        end
        if (!rst_sys_n) begin
            any_gnt = 1'b0;
        end
    end

    // Decode the winner against the SRAM window and drive the memory port;
    // a miss is still granted but never reaches the SRAM.
    always_comb begin
        win_hit         = ((addr_arr[win_idx] & WinMask) == WinBase);
        bus.mem_req_o   = any_gnt && win_hit;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_be_o    = '0;
        bus.mem_wdata_o = '0;
        if (any_gnt) begin
            bus.mem_we_o    = bus.host_we_i[win_idx];
            bus.mem_addr_o  = addr_arr[win_idx];
            bus.mem_be_o    = be_arr[win_idx];
            bus.mem_wdata_o = wdata_arr[win_idx];
        end
    end

    // Read data is only meaningful for a pending hit; otherwise drive zero.
    assign bus.host_rdata_o = (rsp_valid_q && !rsp_err_q) ? bus.mem_rdata_i : '0;
    assign bus.err_count_o  = err_count_q;

    // Track the outstanding response and the round-robin pointer; every
    // grant cycle loads a new response, idle cycles retire it.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            last_q      <= LastHost;
            rsp_valid_q <= 1'b0;
            rsp_host_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= any_gnt;
            if (any_gnt) begin
                last_q     <= win_idx;
                rsp_host_q <= win_idx;
                rsp_err_q  <= !win_hit;
            end
        end
    end

    // Count error responses. Counting when the miss is granted makes the new
    // value visible in the same cycle the error response is presented.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            err_count_q <= '0;
        end else if (any_gnt && !win_hit && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_mem_host_arbiter.sv
// Directed bench for mem_host_arbiter: a round-robin instance backed by a
// small SRAM model, plus a fixed-priority instance for grant ordering.
module tb_mem_host_arbiter;
    logic clk_sys = 1'b0;
    logic rst_sys_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk_sys = ~clk_sys;

    mem_host_arbiter_if #(.NumHosts(2), .AddrWidth(32), .DataWidth(32)) b ();
    mem_host_arbiter_if #(.NumHosts(2), .AddrWidth(32), .DataWidth(32)) f ();

    mem_host_arbiter #(
        .NumHosts(2), .AddrWidth(32), .DataWidth(32),
        .MemStart(32'h0), .MemSize(65536), .RoundRobin(1'b1)
    ) u_rr (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .bus       (b.slave)
    );

    mem_host_arbiter #(
        .NumHosts(2), .AddrWidth(32), .DataWidth(32),
        .MemStart(32'h0), .MemSize(65536), .RoundRobin(1'b0)
    ) u_fp (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .bus       (f.slave)
    );

    // SRAM model: one-cycle latency; unwritten words read as {A5A5, addr[15:0]}
    bit [31:0] mem_words [16384];
    bit        mem_wr    [16384];

    always @(posedge clk_sys) begin
        b.mem_rvalid_i <= b.mem_req_o;
        b.mem_rdata_i  <= 32'h0;
        if (b.mem_req_o) begin
            if (b.mem_we_o) begin
                for (int k = 0; k < 4; k++) begin
                    if (b.mem_be_o[k]) begin
                        mem_words[b.mem_addr_o[15:2]][k*8 +: 8] <= b.mem_wdata_o[k*8 +: 8];
                    end
                end
                mem_wr[b.mem_addr_o[15:2]] <= 1'b1;
            end else if (mem_wr[b.mem_addr_o[15:2]]) begin
                b.mem_rdata_i <= mem_words[b.mem_addr_o[15:2]];
            end else begin
                b.mem_rdata_i <= {16'hA5A5, b.mem_addr_o[15:2], 2'b00};
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        $display("[TB] %0t %s observed=%0h expected=%0h", $time, tag, obs, exp);
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        rst_sys_n      = 1'b0;
        b.host_req_i   = 2'b11;
        b.host_we_i    = 2'b00;
        b.host_addr_i  = {32'h80, 32'h80};
        b.host_be_i    = 8'hFF;
        b.host_wdata_i = '0;
        f.host_req_i   = 2'b00;
        f.host_we_i    = 2'b00;
        f.host_addr_i  = '0;
        f.host_be_i    = 8'hFF;
        f.host_wdata_i = '0;
        f.mem_rvalid_i = 1'b0;
        f.mem_rdata_i  = '0;

        // reset state, with requests already pending
        repeat (3) cyc();
        chk("rst_gnt",      64'(b.host_gnt_o),    64'h0);
        chk("rst_rvalid",   64'(b.host_rvalid_o), 64'h0);
        chk("rst_err",      64'(b.host_err_o),    64'h0);
        chk("rst_rdata",    64'(b.host_rdata_o),  64'h0);
        chk("rst_mem_req",  64'(b.mem_req_o),     64'h0);
        chk("rst_errcnt",   64'(b.err_count_o),   64'h0);

        // round-robin alternation on a shared read of 0x80
        rst_sys_n = 1'b1;
        #1;
        chk("rr0_gnt",      64'(b.host_gnt_o),    64'h1);
        chk("rr0_mem_req",  64'(b.mem_req_o),     64'h1);
        chk("rr0_mem_addr", 64'(b.mem_addr_o),    64'h80);
        chk("rr0_rvalid",   64'(b.host_rvalid_o), 64'h0);
        cyc(); #1;
        chk("rr1_gnt",      64'(b.host_gnt_o),    64'h2);
        chk("rr1_rvalid",   64'(b.host_rvalid_o), 64'h1);
        chk("rr1_rdata",    64'(b.host_rdata_o),  64'hA5A5_0080);
        cyc(); #1;
        chk("rr2_gnt",      64'(b.host_gnt_o),    64'h1);
        chk("rr2_rvalid",   64'(b.host_rvalid_o), 64'h2);
        chk("rr2_rdata",    64'(b.host_rdata_o),  64'hA5A5_0080);
        cyc(); #1;
        chk("rr3_gnt",      64'(b.host_gnt_o),    64'h2);
        chk("rr3_rvalid",   64'(b.host_rvalid_o), 64'h1);

        // host 1 write then read back of 0x1000
        cyc();
        b.host_req_i   = 2'b10;
        b.host_we_i    = 2'b10;
        b.host_addr_i  = {32'h0000_1000, 32'h80};
        b.host_be_i    = 8'hF0;
        b.host_wdata_i = {32'hDEAD_BEEF, 32'h0};
        #1;
        chk("wr_gnt",       64'(b.host_gnt_o),    64'h2);
        chk("wr_mem_we",    64'(b.mem_we_o),      64'h1);
        chk("wr_mem_addr",  64'(b.mem_addr_o),    64'h1000);
        chk("wr_mem_be",    64'(b.mem_be_o),      64'hF);
        chk("wr_mem_wdata", 64'(b.mem_wdata_o),   64'hDEAD_BEEF);
        chk("wr_prev_rvld", 64'(b.host_rvalid_o), 64'h2);
        cyc();
        b.host_we_i = 2'b00;
        #1;
        chk("wr_rsp_rvld",  64'(b.host_rvalid_o), 64'h2);
        chk("wr_rsp_err",   64'(b.host_err_o),    64'h0);
        chk("rd_mem_we",    64'(b.mem_we_o),      64'h0);
        cyc();
        b.host_req_i = 2'b00;
        #1;
        chk("rd_rvalid",    64'(b.host_rvalid_o), 64'h2);
        chk("rd_rdata",     64'(b.host_rdata_o),  64'hDEAD_BEEF);
        chk("idle_gnt",     64'(b.host_gnt_o),    64'h0);
        chk("idle_mem_req", 64'(b.mem_req_o),     64'h0);
        chk("idle_mem_adr", 64'(b.mem_addr_o),    64'h0);
        cyc(); #1;
        chk("idle_rvalid",  64'(b.host_rvalid_o), 64'h0);

        // unmapped access, then both ends of the window
        cyc();
        b.host_req_i  = 2'b10;
        b.host_addr_i = {32'h0001_0000, 32'h80};
        #1;
        chk("miss_gnt",     64'(b.host_gnt_o),    64'h2);
        chk("miss_mem_req", 64'(b.mem_req_o),     64'h0);
        chk("miss_errcnt0", 64'(b.err_count_o),   64'h0);
        cyc();
        b.host_addr_i = {32'h0000_FFFC, 32'h80};
        #1;
        chk("miss_rvalid",  64'(b.host_rvalid_o), 64'h2);
        chk("miss_err",     64'(b.host_err_o),    64'h2);
        chk("miss_rdata",   64'(b.host_rdata_o),  64'h0);
        chk("miss_errcnt1", 64'(b.err_count_o),   64'h1);
        chk("fffc_mem_req", 64'(b.mem_req_o),     64'h1);
        cyc();
        b.host_addr_i = {32'h0000_FFFF, 32'h80};
        #1;
        chk("fffc_rvalid",  64'(b.host_rvalid_o), 64'h2);
        chk("fffc_err",     64'(b.host_err_o),    64'h0);
        chk("ffff_mem_req", 64'(b.mem_req_o),     64'h1);
        chk("fffc_errcnt",  64'(b.err_count_o),   64'h1);
        cyc();
        b.host_req_i = 2'b00;
        #1;
        chk("ffff_rvalid",  64'(b.host_rvalid_o), 64'h2);
        chk("ffff_err",     64'(b.host_err_o),    64'h0);

        // saturation of the error counter from 0xFFFE
        force u_rr.err_count_q = 16'hFFFE;
        #1;
        release u_rr.err_count_q;
        #1;
        chk("sat_preload",  64'(b.err_count_o),   64'hFFFE);
        cyc();
        b.host_req_i  = 2'b10;
        b.host_addr_i = {32'h0001_0000, 32'h80};
        #1;
        chk("sat_c0",       64'(b.err_count_o),   64'hFFFE);
        cyc(); #1;
        chk("sat_c1",       64'(b.err_count_o),   64'hFFFF);
        cyc(); #1;
        chk("sat_c2",       64'(b.err_count_o),   64'hFFFF);
        cyc();
        b.host_req_i = 2'b00;
        #1;
        chk("sat_c3",       64'(b.err_count_o),   64'hFFFF);
        chk("sat_err",      64'(b.host_err_o),    64'h2);
        cyc(); #1;
        chk("sat_c4",       64'(b.err_count_o),   64'hFFFF);

        // reset right after a grant drops the pending response
        cyc();
        b.host_req_i  = 2'b11;
        b.host_addr_i = {32'h80, 32'h80};
        #1;
        chk("mrst_gnt",     64'(b.host_gnt_o),    64'h1);
        cyc();
        rst_sys_n = 1'b0;
        #1;
        chk("mrst_rvalid",  64'(b.host_rvalid_o), 64'h0);
        chk("mrst_gnt_rst", 64'(b.host_gnt_o),    64'h0);
        chk("mrst_errcnt",  64'(b.err_count_o),   64'h0);
        cyc();
        cyc();
        rst_sys_n = 1'b1;
        #1;
        chk("post_gnt0",    64'(b.host_gnt_o),    64'h1);
        chk("post_rvalid0", 64'(b.host_rvalid_o), 64'h0);
        cyc(); #1;
        chk("post_gnt1",    64'(b.host_gnt_o),    64'h2);
        chk("post_rvalid1", 64'(b.host_rvalid_o), 64'h1);

        // fixed priority: host 0 always wins while requesting
        cyc();
        b.host_req_i = 2'b00;
        f.host_req_i = 2'b11;
        f.host_addr_i = {32'h80, 32'h80};
        #1;
        chk("fp_gnt0",      64'(f.host_gnt_o),    64'h1);
        cyc(); #1;
        chk("fp_gnt1",      64'(f.host_gnt_o),    64'h1);
        cyc(); #1;
        chk("fp_gnt2",      64'(f.host_gnt_o),    64'h1);
        cyc();
        f.host_req_i = 2'b10;
        #1;
        chk("fp_gnt_h1",    64'(f.host_gnt_o),    64'h2);
        cyc();
        f.host_req_i = 2'b00;
        #1;
        chk("fp_idle",      64'(f.host_gnt_o),    64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
